key_decoder: RTL and testbench
==============================

# key_decoder

Translates one keypad row/column contact pair into the 4-bit hex code of the pressed key on a 4x4 matrix keypad. It sits between the keypad scanner, which supplies one-hot row and column vectors, and the debounce and display logic. The decode path is purely combinational; a registered copy plus a validity flag and a new-key strobe are provided for synchronous consumers.

## Interface
- No parameters; the keypad map is fixed.
- clk  in  1  system clock; all registers update on its rising edge.
- reset  in  1  synchronous, active-high reset.
- r  in  4  row vector, one-hot; r[3] is top row, r[0] is bottom row.
- c  in  4  column vector, one-hot; c[0] is left column, c[3] is right column.
- value  out  4  combinational key code for (r, c).
- valid  out  1  combinational; 1 when r and c are each exactly one-hot.
- key_q  out  4  registered key code, last valid decode.
- key_valid_q  out  1  registered copy of valid.
- new_key  out  1  one-cycle strobe marking a newly registered key.

## Operation
- Keypad map, listed as row, then columns c[0], c[1], c[2], c[3]:
  - r[3]: 1, 2, 3, A
  - r[2]: 4, 5, 6, B
  - r[1]: 7, 8, 9, C
  - r[0]: E, 0, F, D
- valid = (r one-hot) AND (c one-hot). All-zero vectors and multi-hot vectors are invalid.
- If valid = 0, value = 4'h0. Consumers must qualify value with valid, because 4'h0 is also a real key.
- Register update on each clk edge, when reset = 0:
  - key_valid_q <= valid.
  - If valid = 1, key_q <= value; otherwise key_q holds its previous value.
  - new_key <= valid AND (key_valid_q = 0 OR value != key_q).
- Holding the same key pressed produces exactly one new_key pulse.
- Moving directly from one valid key to another produces one new_key pulse for the new key.

## Timing
- value and valid: zero-cycle combinational path from r and c; no clock dependence and no reset dependence.
- key_q, key_valid_q, new_key: 1-cycle latency from r and c.
- new_key is high for exactly one cycle per accepted key.
- Reset value of key_q is 4'h0; reset value of key_valid_q is 0; reset value of new_key is 0.
- Reset overrides any simultaneous valid input.
- On the first edge after reset is released with a valid key present, new_key = 1.
- A glitch to an invalid pattern between two presses of the same key re-arms the strobe: key_valid_q drops, so the next valid cycle pulses new_key.

## Structure
- Shared package keypad_pkg holds:
  - Typedef key_code_t, logic [3:0].
  - The 16 key code constants, KEY_0 through KEY_F.
  - Function is_onehot4.
- One combinational sub-module, keypad_map, that maps (r, c) to value/valid. It is reused by the scanner.
- key_decoder instantiates keypad_map and adds the three output registers.

## Test plan
- Sweep all 16 one-hot (r, c) pairs and check value combinationally after settling:
  - r=1000: c=0001 -> 1, c=0010 -> 2, c=0100 -> 3, c=1000 -> A.
  - r=0100 -> 4, 5, 6, B.
  - r=0010 -> 7, 8, 9, C.
  - r=0001 -> E, 0, F, D.
  - valid = 1 throughout.
- Invalid patterns: r=0000; r=1100 with c=0001; r=1000 with c=0011 -> value = 0, valid = 0, key_q unchanged, no new_key.
- Assert reset with r=1000, c=0001 held -> key_q = 0, key_valid_q = 0, new_key = 0. Deassert -> next edge gives key_q = 1, key_valid_q = 1, new_key = 1 for one cycle.
- Hold r=0001, c=0010 for 5 cycles -> key_q = 0, new_key high only on the first cycle.
- Change r=1000, c=1000 to r=0100, c=1000 with no gap -> key_q goes A then B, with new_key pulsed for each.
- Key 5, then an invalid cycle (r=0000), then key 5 again -> two new_key pulses; key_q stays 5 through the gap.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key code type, key constants and one-hot helper.
package keypad_pkg;

  localparam int unsigned KEY_W  = 4;
  localparam int unsigned LINE_W = 4;

  typedef logic [KEY_W-1:0] key_code_t;

  localparam key_code_t KEY_0 = 4'h0;
  localparam key_code_t KEY_1 = 4'h1;
  localparam key_code_t KEY_2 = 4'h2;
  localparam key_code_t KEY_3 = 4'h3;
  localparam key_code_t KEY_4 = 4'h4;
  localparam key_code_t KEY_5 = 4'h5;
  localparam key_code_t KEY_6 = 4'h6;
  localparam key_code_t KEY_7 = 4'h7;
  localparam key_code_t KEY_8 = 4'h8;
  localparam key_code_t KEY_9 = 4'h9;
  localparam key_code_t KEY_A = 4'hA;
  localparam key_code_t KEY_B = 4'hB;
  localparam key_code_t KEY_C = 4'hC;
  localparam key_code_t KEY_D = 4'hD;
  localparam key_code_t KEY_E = 4'hE;
  localparam key_code_t KEY_F = 4'hF;

  // True when exactly one bit of v is set; clearing the lowest set bit must leave zero.
  function automatic logic is_onehot4(input logic [LINE_W-1:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/keypad_map.sv
// Combinational 4x4 keypad map: one-hot row/column contact pair -> hex key code.
// Ports:
//   r     in  row vector, one-hot, r[3] = top row
//   c     in  column vector, one-hot, c[0] = left column
//   value out key code, 0 when the pair is not valid
//   valid out r and c each exactly one-hot
module keypad_map
  import keypad_pkg::*;
(
  input  logic [LINE_W-1:0] r,
  input  logic [LINE_W-1:0] c,
  output key_code_t         value,
  output logic              valid
);

  // Decode; the table only matches one-hot pairs, so anything else falls to KEY_0.
  always_comb begin
    value = KEY_0;
    valid = is_onehot4(r) && is_onehot4(c);
    case ({r, c})
      8'b1000_0001: value = KEY_1;
      8'b1000_0010: value = KEY_2;
      8'b1000_0100: value = KEY_3;
      8'b1000_1000: value = KEY_A;
      8'b0100_0001: value = KEY_4;
      8'b0100_0010: value = KEY_5;
      8'b0100_0100: value = KEY_6;
      8'b0100_1000: value = KEY_B;
      8'b0010_0001: value = KEY_7;
      8'b0010_0010: value = KEY_8;
      8'b0010_0100: value = KEY_9;
      8'b0010_1000: value = KEY_C;
      8'b0001_0001: value = KEY_E;
      8'b0001_0010: value = KEY_0;
      8'b0001_0100: value = KEY_F;
      8'b0001_1000: value = KEY_D;
      default:      value = KEY_0;
    endcase
  end

endmodule

// File: rtl/key_decoder.sv
// Keypad key decoder: combinational decode plus registered key, validity and new-key strobe.
// Ports:
//   clk         in  system clock
//   reset       in  synchronous active-high reset
//   r, c        in  one-hot row / column vectors from the scanner
//   value       out combinational key code (qualify with valid)
//   valid       out combinational pair-is-one-hot flag
//   key_q       out last valid key code, registered
//   key_valid_q out registered valid
//   new_key     out one-cycle strobe for a newly registered key
module key_decoder
  import keypad_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [LINE_W-1:0] r,
  input  logic [LINE_W-1:0] c,
  output key_code_t         value,
  output logic              valid,
  output key_code_t         key_q,
  output logic              key_valid_q,
  output logic              new_key
);

  keypad_map u_map (
    .r     (r),
    .c     (c),
    .value (value),
    .valid (valid)
  );

  // A key is new if the previous cycle was invalid or a different key was held.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_q       <= KEY_0;
      key_valid_q <= 1'b0;
      new_key     <= 1'b0;
    end else begin
      key_valid_q <= valid;
      new_key     <= valid && (!key_valid_q || (value != key_q));
      if (valid) begin
        key_q <= value;
      end
    end
  end

endmodule

// File: tb/tb_key_decoder.sv
// Self-checking bench for key_decoder against a table-driven keypad model.
module tb_key_decoder;
  import keypad_pkg::*;

  logic       clk;
  logic       reset;
  logic [3:0] r;
  logic [3:0] c;
  key_code_t  value;
  logic       valid;
  key_code_t  key_q;
  logic       key_valid_q;
  logic       new_key;

  int checks = 0;
  int errors = 0;

  // Reference state
  key_code_t m_q;
  logic      m_vq;
  logic      m_nk;

  // Keypad layout as printed on the pad: [row from top][column from left]
  key_code_t kmap [4][4] = '{
    '{KEY_1, KEY_2, KEY_3, KEY_A},
    '{KEY_4, KEY_5, KEY_6, KEY_B},
    '{KEY_7, KEY_8, KEY_9, KEY_C},
    '{KEY_E, KEY_0, KEY_F, KEY_D}
  };

  key_decoder dut (
    .clk         (clk),
    .reset       (reset),
    .r           (r),
    .c           (c),
    .value       (value),
    .valid       (valid),
    .key_q       (key_q),
    .key_valid_q (key_valid_q),
    .new_key     (new_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_comb(input logic [3:0] rr, input logic [3:0] cc,
                                     output key_code_t v, output logic ok);
    int ri;
    int ci;
    ri = 0;
    ci = 0;
    ok = ($countones(rr) == 1) && ($countones(cc) == 1);
    v  = KEY_0;
    if (ok) begin
      for (int i = 0; i < 4; i++) begin
        if (rr[i]) ri = 3 - i;
        if (cc[i]) ci = i;
      end
      v = kmap[ri][ci];
    end
  endfunction

  task automatic drive(input logic [3:0] rr, input logic [3:0] cc, input logic rst);
    r     = rr;
    c     = cc;
    reset = rst;
    #1;
  endtask

  // One rising edge; the model advances with the same inputs the DUT sees.
  task automatic tick();
    key_code_t v;
    logic      ok;
    model_comb(r, c, v, ok);
    @(posedge clk);
    if (reset) begin
      m_q  = KEY_0;
      m_vq = 1'b0;
      m_nk = 1'b0;
    end else begin
      m_nk = ok && (!m_vq || (v != m_q));
      m_vq = ok;
      if (ok) m_q = v;
    end
    #1;
  endtask

  task automatic test_reset();
    drive(4'b1000, 4'b0001, 1'b1);
    tick();
    tick();
    checks++;
    if (key_q !== KEY_0) begin errors++; $display("FAIL reset_key_q got %h exp %h", key_q, KEY_0); end
    checks++;
    if (key_valid_q !== 1'b0) begin errors++; $display("FAIL reset_key_valid_q got %b exp 0", key_valid_q); end
    checks++;
    if (new_key !== 1'b0) begin errors++; $display("FAIL reset_new_key got %b exp 0", new_key); end
    drive(4'b1000, 4'b0001, 1'b0);
    tick();
    checks++;
    if (key_q !== KEY_1 || key_valid_q !== 1'b1 || new_key !== 1'b1) begin
      errors++;
      $display("FAIL release_first_edge got q=%h v=%b nk=%b exp q=1 v=1 nk=1", key_q, key_valid_q, new_key);
    end
    tick();
    checks++;
    if (new_key !== 1'b0) begin errors++; $display("FAIL release_second_edge new_key got %b exp 0", new_key); end
  endtask

  task automatic test_sweep();
    logic [3:0] rr;
    logic [3:0] cc;
    key_code_t  ev;
    logic       eok;
    for (int ri = 0; ri < 4; ri++) begin
      for (int ci = 0; ci < 4; ci++) begin
        rr = 4'b1000 >> ri;
        cc = 4'b0001 << ci;
        drive(rr, cc, 1'b0);
        model_comb(rr, cc, ev, eok);
        checks++;
        if (value !== ev || valid !== 1'b1) begin
          errors++;
          $display("FAIL sweep_comb r=%b c=%b got value=%h valid=%b exp value=%h valid=1", rr, cc, value, valid, ev);
        end
        tick();
        checks++;
        if (key_q !== m_q || new_key !== m_nk) begin
          errors++;
          $display("FAIL sweep_reg r=%b c=%b got q=%h nk=%b exp q=%h nk=%b", rr, cc, key_q, new_key, m_q, m_nk);
        end
      end
    end
  endtask

  task automatic test_invalid();
    logic [3:0] pr [3] = '{4'b0000, 4'b1100, 4'b1000};
    logic [3:0] pc [3] = '{4'b0001, 4'b0001, 4'b0011};
    drive(4'b0010, 4'b0001, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(pr[i], pc[i], 1'b0);
      checks++;
      if (value !== KEY_0 || valid !== 1'b0) begin
        errors++;
        $display("FAIL invalid_comb r=%b c=%b got value=%h valid=%b exp value=0 valid=0", pr[i], pc[i], value, valid);
      end
      tick();
      checks++;
      if (key_q !== KEY_7 || new_key !== 1'b0 || key_valid_q !== 1'b0) begin
        errors++;
        $display("FAIL invalid_reg r=%b c=%b got q=%h nk=%b v=%b exp q=7 nk=0 v=0", pr[i], pc[i], key_q, new_key, key_valid_q);
      end
    end
  endtask

  task automatic test_hold();
    drive(4'b0001, 4'b0010, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (key_q !== KEY_0 || new_key !== (i == 0)) begin
        errors++;
        $display("FAIL hold cycle=%0d got q=%h nk=%b exp q=0 nk=%b", i, key_q, new_key, (i == 0));
      end
    end
  endtask

  task automatic test_back_to_back();
    drive(4'b1000, 4'b1000, 1'b0);
    tick();
    checks++;
    if (key_q !== KEY_A || new_key !== 1'b1) begin
      errors++; $display("FAIL b2b_first got q=%h nk=%b exp q=a nk=1", key_q, new_key);
    end
    drive(4'b0100, 4'b1000, 1'b0);
    tick();
    checks++;
    if (key_q !== KEY_B || new_key !== 1'b1) begin
      errors++; $display("FAIL b2b_second got q=%h nk=%b exp q=b nk=1", key_q, new_key);
    end
  endtask

  task automatic test_glitch();
    logic [3:0] gr [4] = '{4'b0100, 4'b0100, 4'b0000, 4'b0100};
    logic       enk [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      drive(gr[i], 4'b0010, 1'b0);
      tick();
      checks++;
      if (key_q !== KEY_5 || new_key !== enk[i]) begin
        errors++;
        $display("FAIL glitch step=%0d got q=%h nk=%b exp q=5 nk=%b", i, key_q, new_key, enk[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] rr;
    logic [3:0] cc;
    logic       rst;
    key_code_t  ev;
    logic       eok;
    for (int n = 0; n < 300; n++) begin
      rr  = ($urandom_range(0, 3) != 0) ? 4'(4'b0001 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      cc  = ($urandom_range(0, 3) != 0) ? 4'(4'b0001 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) rr = r; // repeat row to exercise holds
      if ($urandom_range(0, 3) == 0) cc = c;
      rst = ($urandom_range(0, 31) == 0);
      drive(rr, cc, rst);
      model_comb(rr, cc, ev, eok);
      checks++;
      if (value !== ev || valid !== eok) begin
        errors++;
        $display("FAIL rand_comb n=%0d r=%b c=%b got value=%h valid=%b exp value=%h valid=%b", n, rr, cc, value, valid, ev, eok);
      end
      tick();
      checks++;
      if (key_q !== m_q || key_valid_q !== m_vq || new_key !== m_nk) begin
        errors++;
        $display("FAIL rand_reg n=%0d got q=%h v=%b nk=%b exp q=%h v=%b nk=%b", n, key_q, key_valid_q, new_key, m_q, m_vq, m_nk);
      end
    end
  endtask

  initial begin
    r     = 4'b0000;
    c     = 4'b0000;
    reset = 1'b1;
    m_q   = KEY_0;
    m_vq  = 1'b0;
    m_nk  = 1'b0;
    test_reset();
    test_sweep();
    test_invalid();
    test_hold();
    test_back_to_back();
    test_glitch();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout bench did not finish");
    $fatal(1);
  end

endmodule
